cc_miss_controller: RTL and testbench

- Sequencing FSM for the cache-controller read path. It gates new lookups and consumes the one-cycle-delayed hit/miss result and address fields from the tag-comparison stage.
- On a hit, it forwards the data-SRAM line to the response serializer.
- On a miss, it issues an AXI-style line fill to memory, assembles the beats, and writes the data and tag SRAMs (valid=1). It then delivers the filled line to the serializer.
- It sits between the request interface, the tag comparator, the tag/data SRAMs, the memory read channel and the response serializer.

---
 rtl/cc_miss_controller.sv | 177 +++++++++++++++++
 tb/tb_cc_miss_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_controller.sv
// Read-path sequencer for the cache controller.
// Takes the comparator's hit/miss result one cycle after a request handshake.
// A hit returns the data-SRAM line straight to the response serializer.
// A miss fetches the line from memory as a BEATS-long burst, writes it into
// the tag and data SRAMs, then returns it to the serializer.
// Only one request is in flight at a time.
module cc_miss_controller #(
  parameter int TAG_W  = 17,
  parameter int IDX_W  = 9,
  parameter int OFF_W  = 6,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request side / comparator
  output logic                  req_ready_o,
  input  logic                  hs_pulse_i,
  input  logic                  hit_i,
  input  logic                  miss_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [IDX_W-1:0]      index_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [8*(2**OFF_W)-1:0] data_rdata_i,
  // memory read channel
  output logic [31:0]           mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic [BEAT_W-1:0]     mem_rdata_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rlast_i,
  output logic                  mem_rready_o,
  // tag / data SRAM write port
  output logic                  sram_wren_o,
  output logic [IDX_W-1:0]      sram_waddr_o,
  output logic [TAG_W:0]        tag_wdata_o,
  output logic [8*(2**OFF_W)-1:0] data_wdata_o,
  // response serializer
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*(2**OFF_W)-1:0] out_data_o,
  output logic [OFF_W-1:0]      out_offset_o,
  output logic                  err_o
);

  localparam int LINE_W = 8 * (2**OFF_W);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    AR     = 3'd2,
    RFILL  = 3'd3,
    WRITE  = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Address fields of the request in flight, captured in LOOKUP.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } req_t;

  state_t            state;
  req_t              req_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic              last_cnt;
  logic              beat_ok;

  // The final beat by count is a separate condition from the final beat by rlast.
  // Both conditions are tracked so that a disagreement can be flagged.
  assign last_cnt = (beat_cnt == CNT_W'(BEATS - 1));
  assign beat_ok  = (state == RFILL) && mem_rvalid_i;

  // Burst length is fixed to one full line.
  assign mem_arlen_o = 4'(BEATS - 1);

  // The line buffer feeds both the SRAM write data and the response data.
  // It is only rewritten in LOOKUP and RFILL.
  // The value is therefore stable through WRITE and RESP.
  assign data_wdata_o = line_q;
  assign out_data_o   = line_q;
  assign out_offset_o = req_q.offset;

  // Main sequencer: state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= '0;
      line_q        <= '0;
      beat_cnt      <= '0;
      req_ready_o   <= 1'b0;
      mem_araddr_o  <= '0;
      mem_arvalid_o <= 1'b0;
      mem_rready_o  <= 1'b0;
      sram_wren_o   <= 1'b0;
      sram_waddr_o  <= '0;
      tag_wdata_o   <= '0;
      out_valid_o   <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      sram_wren_o <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (hs_pulse_i) begin
            req_ready_o <= 1'b0;
            state       <= LOOKUP;
          end
        end

        LOOKUP: begin
          req_q <= '{tag: tag_i, index: index_i, offset: offset_i};
          // A simultaneous hit and miss is resolved as a miss.
          if (miss_i) begin
            mem_araddr_o  <= 32'({tag_i, index_i, {OFF_W{1'b0}}});
            mem_arvalid_o <= 1'b1;
            state         <= AR;
          end else if (hit_i) begin
            line_q      <= data_rdata_i;
            out_valid_o <= 1'b1;
            state       <= RESP;
          end
        end

        AR: begin
          if (mem_arready_i) begin
            mem_arvalid_o <= 1'b0;
            mem_rready_o  <= 1'b1;
            beat_cnt      <= '0;
            state         <= RFILL;
          end
        end

        RFILL: begin
          if (beat_ok) begin
            line_q[beat_cnt*BEAT_W +: BEAT_W] <= mem_rdata_i;
            beat_cnt <= beat_cnt + 1'b1;
            if (mem_rlast_i || last_cnt) begin
              // A short or long burst still commits what was received.
              // Bytes that were not filled keep their previous buffer contents.
              if (mem_rlast_i != last_cnt) err_o <= 1'b1;
              mem_rready_o <= 1'b0;
              sram_wren_o  <= 1'b1;
              sram_waddr_o <= req_q.index;
              tag_wdata_o  <= {1'b1, req_q.tag};
              state        <= WRITE;
            end
          end
        end

        WRITE: begin
          sram_waddr_o <= '0;
          tag_wdata_o  <= '0;
          out_valid_o  <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_miss_controller.sv
// Directed bench for cc_miss_controller.
// Expected SRAM writes and responses are queued when a request is issued.
// A negedge monitor checks them off as the DUT produces them.
module tb_cc_miss_controller;

  localparam int TAG_W  = 17;
  localparam int IDX_W  = 9;
  localparam int OFF_W  = 6;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 8;
  localparam int LINE_W = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_ready_o;
  logic              hs_pulse_i;
  logic              hit_i;
  logic              miss_i;
  logic [TAG_W-1:0]  tag_i;
  logic [IDX_W-1:0]  index_i;
  logic [OFF_W-1:0]  offset_i;
  logic [LINE_W-1:0] data_rdata_i;
  logic [31:0]       mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic              mem_arvalid_o;
  logic              mem_arready_i;
  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;
  logic              mem_rlast_i;
  logic              mem_rready_o;
  logic              sram_wren_o;
  logic [IDX_W-1:0]  sram_waddr_o;
  logic [TAG_W:0]    tag_wdata_o;
  logic [LINE_W-1:0] data_wdata_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [LINE_W-1:0] out_data_o;
  logic [OFF_W-1:0]  out_offset_o;
  logic              err_o;

  always #5 clk = ~clk;

  cc_miss_controller #(
    .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .BEAT_W(BEAT_W), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ready_o(req_ready_o), .hs_pulse_i(hs_pulse_i),
    .hit_i(hit_i), .miss_i(miss_i),
    .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
    .data_rdata_i(data_rdata_i),
    .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rlast_i(mem_rlast_i), .mem_rready_o(mem_rready_o),
    .sram_wren_o(sram_wren_o), .sram_waddr_o(sram_waddr_o),
    .tag_wdata_o(tag_wdata_o), .data_wdata_o(data_wdata_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_offset_o(out_offset_o),
    .err_o(err_o)
  );

  typedef struct {
    logic [LINE_W-1:0] data;
    logic [OFF_W-1:0]  off;
  } resp_t;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [TAG_W:0]    tag;
    logic [LINE_W-1:0] data;
  } wr_t;

  resp_t             rq[$];
  wr_t               wq[$];
  int                chk      = 0;
  int                errs     = 0;
  int                wren_cnt = 0;
  int                ar_cyc   = 0;
  logic [LINE_W-1:0] model_line;

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    chk++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: SRAM writes and accepted responses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_arvalid_o) ar_cyc++;
      if (sram_wren_o) begin
        wren_cnt++;
        chk++;
        assert (wq.size() != 0) else begin
          errs++;
          $error("FAIL wr_unexpected got wren=1 exp no write pending");
        end
        if (wq.size() != 0) begin
          wr_t w;
          w = wq.pop_front();
          check("wr_idx", sram_waddr_o, w.idx);
          check("wr_tag", tag_wdata_o, w.tag);
          check("wr_data", data_wdata_o, w.data);
        end
      end
      if (out_valid_o && out_ready_i) begin
        chk++;
        assert (rq.size() != 0) else begin
          errs++;
          $error("FAIL resp_unexpected got response exp none pending");
        end
        if (rq.size() != 0) begin
          resp_t r;
          r = rq.pop_front();
          check("resp_data", out_data_o, r.data);
          check("resp_off", out_offset_o, r.off);
        end
      end
    end
  end

  task automatic check_quiet(input logic exp_rdy);
    check("q_ctrl", {req_ready_o, mem_arvalid_o, mem_rready_o, sram_wren_o,
                     out_valid_o, err_o}, {exp_rdy, 5'b0});
    check("q_araddr", mem_araddr_o, 0);
    check("q_arlen", mem_arlen_o, 4'd7);
    check("q_waddr", sram_waddr_o, 0);
    check("q_tagw", tag_wdata_o, 0);
    check("q_dataw", data_wdata_o, 0);
    check("q_outd", out_data_o, 0);
    check("q_outoff", out_offset_o, 0);
  endtask

  // Entered just after the edge that starts the first RESP cycle.
  task automatic finish_resp(input int bp, input logic [LINE_W-1:0] exp_d,
                             input logic [OFF_W-1:0] exp_off);
    for (int i = 0; i < bp; i++) begin
      out_ready_i = 1'b0;
      @(negedge clk);
      check("bp_valid", out_valid_o, 1'b1);
      check("bp_data", out_data_o, exp_d);
      check("bp_off", out_offset_o, exp_off);
      check("bp_rdy", req_ready_o, 1'b0);
      tick();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    check("resp_valid", out_valid_o, 1'b1);
    check("resp_rdy_low", req_ready_o, 1'b0);
    tick();
    out_ready_i = 1'b0;
    @(negedge clk);
    check("post_rdy", req_ready_o, 1'b1);
    check("post_valid", out_valid_o, 1'b0);
    tick();
  endtask

  task automatic do_hit(input logic [TAG_W-1:0] tg, input logic [IDX_W-1:0] ix,
                        input logic [OFF_W-1:0] of, input logic [LINE_W-1:0] d,
                        input int bp);
    int a0, w0;
    a0 = ar_cyc;
    w0 = wren_cnt;
    hs_pulse_i = 1'b1;
    @(negedge clk);
    check("hit_req_rdy", req_ready_o, 1'b1);
    tick();
    hs_pulse_i = 1'b0;
    hit_i = 1'b1;
    tag_i = tg;
    index_i = ix;
    offset_i = of;
    data_rdata_i = d;
    model_line = d;
    rq.push_back('{data: d, off: of});
    @(negedge clk);
    check("hit_lookup_valid", out_valid_o, 1'b0);
    tick();
    hit_i = 1'b0;
    data_rdata_i = ~d;
    finish_resp(bp, d, of);
    check("hit_no_ar", ar_cyc, a0);
    check("hit_no_wr", wren_cnt, w0);
  endtask

  task automatic do_miss(input logic [TAG_W-1:0] tg, input logic [IDX_W-1:0] ix,
                         input logic [OFF_W-1:0] of, input int ar_delay,
                         input bit gap, input int rlast_at, input int base,
                         input bit both, input logic exp_err, input int bp);
    logic [31:0]       exp_addr;
    logic [LINE_W-1:0] line;
    int                nacc, w0;
    w0 = wren_cnt;
    exp_addr = {tg, ix, 6'b0};
    nacc = (rlast_at < BEATS) ? rlast_at : BEATS;
    line = model_line;
    for (int b = 0; b < nacc; b++) line[b*BEAT_W +: BEAT_W] = 64'(base + b);
    wq.push_back('{idx: ix, tag: {1'b1, tg}, data: line});
    rq.push_back('{data: line, off: of});

    hs_pulse_i = 1'b1;
    @(negedge clk);
    tick();
    hs_pulse_i = 1'b0;
    miss_i = 1'b1;
    hit_i = both;
    tag_i = tg;
    index_i = ix;
    offset_i = of;
    data_rdata_i = ~line;
    @(negedge clk);
    tick();
    miss_i = 1'b0;
    hit_i = 1'b0;
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      check("ar_wait_valid", mem_arvalid_o, 1'b1);
      check("ar_wait_addr", mem_araddr_o, exp_addr);
      check("ar_wait_rready", mem_rready_o, 1'b0);
      tick();
    end
    mem_arready_i = 1'b1;
    @(negedge clk);
    check("ar_valid", mem_arvalid_o, 1'b1);
    check("ar_addr", mem_araddr_o, exp_addr);
    check("ar_len", mem_arlen_o, 4'd7);
    tick();
    mem_arready_i = 1'b0;
    for (int b = 0; b < nacc; b++) begin
      if (gap) begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 64'hDEAD_BEEF_0000_0000 + 64'(b);
        @(negedge clk);
        check("gap_rready", mem_rready_o, 1'b1);
        tick();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 64'(base + b);
      mem_rlast_i = (b == rlast_at - 1);
      @(negedge clk);
      check("beat_rready", mem_rready_o, 1'b1);
      check("beat_no_wr", sram_wren_o, 1'b0);
      tick();
    end
    // A stray beat in WRITE must not be taken.
    mem_rvalid_i = 1'b1;
    mem_rlast_i = 1'b1;
    mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check("write_wren", sram_wren_o, 1'b1);
    check("write_rready", mem_rready_o, 1'b0);
    check("write_valid", out_valid_o, 1'b0);
    check("write_err", err_o, exp_err);
    tick();
    mem_rvalid_i = 1'b0;
    mem_rlast_i = 1'b0;
    model_line = line;
    finish_resp(bp, line, of);
    check("miss_one_write", wren_cnt, w0 + 1);
  endtask

  logic [LINE_W-1:0] pat_a, pat_b;

  initial begin
    int w0;
    rst_n = 1'b0;
    hs_pulse_i = 1'b0; hit_i = 1'b0; miss_i = 1'b0;
    tag_i = '0; index_i = '0; offset_i = '0; data_rdata_i = '0;
    mem_arready_i = 1'b0; mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    out_ready_i = 1'b0;
    model_line = '0;
    pat_a = {16{32'hA5A5_1234}};
    pat_b = {16{32'h5A5A_8765}};

    // Reset state
    @(negedge clk);
    check_quiet(1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_rdy", req_ready_o, 1'b1);
    tick();

    // Hit, then a clean miss fill with a delayed arready
    do_hit(17'h1ABCD, 9'd5, 6'h10, pat_a, 0);
    do_miss(17'h1ABCD, 9'd5, 6'h10, 3, 1'b0, 8, 0, 1'b0, 1'b0, 0);
    // Gapped beats; hit and miss asserted together behave as a miss
    do_miss(17'h0F00F, 9'h1FF, 6'h3F, 0, 1'b1, 8, 32'h100, 1'b1, 1'b0, 0);
    // Response backpressure
    do_hit(17'h12345, 9'd0, 6'h00, pat_b, 5);
    // Early rlast: only 4 beats are filled, and err_o sets
    do_miss(17'h1FFFF, 9'h0AA, 6'h08, 1, 1'b0, 4, 32'h20, 1'b0, 1'b1, 2);
    @(negedge clk);
    check("err_sticky", err_o, 1'b1);
    tick();

    // Reset in the middle of a fill
    w0 = wren_cnt;
    hs_pulse_i = 1'b1;
    tick();
    hs_pulse_i = 1'b0;
    miss_i = 1'b1;
    tag_i = 17'h00777;
    index_i = 9'd3;
    tick();
    miss_i = 1'b0;
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 64'(32'h300 + b);
      tick();
    end
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet(1'b0);
    tick();
    rst_n = 1'b1;
    model_line = '0;
    tick();
    @(negedge clk);
    check("rst_no_wr", wren_cnt, w0);
    check("rst_idle_rdy", req_ready_o, 1'b1);
    tick();
    do_hit(17'h0ACE1, 9'd77, 6'h2A, pat_a ^ pat_b, 1);
    check("final_no_wr", wren_cnt, w0);
    check("sb_resp_empty", rq.size(), 0);
    check("sb_wr_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
